gcd_job_scheduler: RTL and testbench

//  Shares one GCD unit (controller + datapath) between N requesters. Round-robin picks a

---
 rtl/gcd_sched_pkg.sv | 26 ++
 rtl/gcd_job_scheduler_if.sv | 31 +++
 rtl/gcd_rr_arbiter.sv | 48 ++++
 rtl/gcd_job_scheduler.sv | 130 +++++++++++++
 tb/tb_gcd_job_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_sched_pkg.sv
// ============================================================================
// gcd_sched_pkg : shared state encoding and width helper for the GCD job scheduler
// Revision 1.0
// ============================================================================
`default_nettype none

package gcd_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_RUN    = 3'd2,
      ST_RESP   = 3'd3,
      ST_CLEAR  = 3'd4
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gcd_job_scheduler_if.sv
// ============================================================================
// gcd_job_scheduler_if : requester-side request/response bundle of the scheduler
// Revision 1.0
// ============================================================================
`default_nettype none

interface gcd_job_scheduler_if #(
   parameter int N = 4,
   parameter int W = 8
);
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   resp_valid;
   logic [N-1:0]   resp_ready;
   logic [W-1:0]   resp_data;
   logic           resp_err;

   modport master (
      output req_valid, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

`default_nettype wire

// File: rtl/gcd_rr_arbiter.sv
// ============================================================================
// gcd_rr_arbiter : round-robin pick of the first request after the last winner
// Revision 1.0
// ============================================================================
`default_nettype none

module gcd_rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic           en,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] grant_id
);
   logic [IDW-1:0] ptr;
   logic           found;
   int             idx;

   // Search starts one past the last winner so the last winner is seen last.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 1; k <= N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = IDW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr <= IDW'(N - 1);
      else if (en && found)
         ptr <= grant_id;
   end

endmodule

`default_nettype wire

// File: rtl/gcd_job_scheduler.sv
// ============================================================================
// gcd_job_scheduler : shares one GCD unit between N requesters, one job at a time
// Revision 1.0
// ============================================================================
`default_nettype none

module gcd_job_scheduler
   import gcd_sched_pkg::*;
#(
   parameter int N       = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic                clk,
   input  logic                reset,
   gcd_job_scheduler_if.slave  bus,
   output logic                gcd_start,
   output logic                gcd_reset,
   output logic [W-1:0]        gcd_a,
   output logic [W-1:0]        gcd_b,
   input  logic [W-1:0]        gcd_result,
   input  logic                gcd_result_rdy,
   output logic                busy
);
   localparam int IDW = (clog2(N) < 1) ? 1 : clog2(N);
   localparam int CW  = clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] COUNT_MAX  = {CW{1'b1}};

   state_t         state;
   state_t         state_next;
   logic [IDW-1:0] id;
   logic [IDW-1:0] grant_id;
   logic [N-1:0]   grant;
   logic [CW-1:0]  count;
   logic [W-1:0]   resp_data_q;
   logic           resp_err_q;
   logic           accept;
   logic           timed_out;

   assign accept    = (state == ST_IDLE) && (|bus.req_valid);
   assign timed_out = (count == COUNT_LAST);

   gcd_rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
      .clk      (clk),
      .reset    (reset),
      .req      (bus.req_valid),
      .en       (accept),
      .grant    (grant),
      .grant_id (grant_id)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next     = state;
      gcd_start      = 1'b0;
      gcd_reset      = reset;
      busy           = (state != ST_IDLE);
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      case (state)
         ST_IDLE: begin
            // Gate with reset so no accept pulse leaks out while flops are held.
            if (!reset) bus.req_ready = grant;
            if (accept) state_next = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            gcd_start  = 1'b1;
            state_next = ST_RUN;
         end
         ST_RUN: begin
            if (gcd_result_rdy || timed_out) state_next = ST_RESP;
         end
         ST_RESP: begin
            bus.resp_valid = {{(N-1){1'b0}}, 1'b1} << id;
            if (bus.resp_ready[id]) state_next = ST_CLEAR;
         end
         ST_CLEAR: begin
            gcd_reset  = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id          <= '0;
         gcd_a       <= '0;
         gcd_b       <= '0;
         count       <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  id    <= grant_id;
                  gcd_a <= bus.req_a[int'(grant_id)*W +: W];
                  gcd_b <= bus.req_b[int'(grant_id)*W +: W];
               end
            end
            ST_LAUNCH: count <= '0;
            ST_RUN: begin
               if (gcd_result_rdy) begin
                  resp_data_q <= gcd_result;
                  resp_err_q  <= 1'b0;
               end else begin
                  if (count != COUNT_MAX) count <= count + 1'b1;
                  if (timed_out) begin
                     resp_data_q <= '0;
                     resp_err_q  <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.resp_data = resp_data_q;
   assign bus.resp_err  = resp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_job_scheduler.sv
// ============================================================================
// tb_gcd_job_scheduler : drives the scheduler against a delayed behavioural GCD unit
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_gcd_job_scheduler;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         gcd_start, gcd_reset, busy;
   logic [W-1:0] gcd_a, gcd_b;
   logic [W-1:0] gcd_result;
   logic         gcd_result_rdy;

   int total = 0;
   int bad   = 0;
   int delay_cfg = 0;
   bit never_rdy = 1'b0;

   gcd_job_scheduler_if #(.N(N), .W(W)) sif ();

   gcd_job_scheduler #(.N(N), .W(W), .TIMEOUT(TO)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (sif),
      .gcd_start      (gcd_start),
      .gcd_reset      (gcd_reset),
      .gcd_a          (gcd_a),
      .gcd_b          (gcd_b),
      .gcd_result     (gcd_result),
      .gcd_result_rdy (gcd_result_rdy),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x, y, t;
      x = a; y = b;
      while (y != 0) begin
         t = x % y; x = y; y = t;
      end
      return x;
   endfunction

   function automatic int rr_pick(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++)
         if (req[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   // Behavioural GCD unit: answer appears delay_cfg cycles after start, sticky until reset.
   logic [W-1:0] m_res;
   logic         m_rdy;
   bit           m_run;
   int           m_cnt;
   always @(posedge clk) begin
      if (gcd_reset) begin
         m_rdy <= 1'b0; m_run <= 1'b0; m_res <= '0; m_cnt <= 0;
      end else if (gcd_start) begin
         m_res <= gcd_ref(gcd_a, gcd_b);
         if (never_rdy)           m_run <= 1'b0;
         else if (delay_cfg == 0) m_rdy <= 1'b1;
         else begin m_run <= 1'b1; m_cnt <= delay_cfg - 1; end
      end else if (m_run && !never_rdy) begin
         if (m_cnt == 0) begin m_rdy <= 1'b1; m_run <= 1'b0; end
         else m_cnt <= m_cnt - 1;
      end
   end
   assign gcd_result     = m_res;
   assign gcd_result_rdy = m_rdy;

   task automatic do_job(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         output bit ok, output logic [N-1:0] rr, output logic [W-1:0] data,
                         output logic err, output int starts, output int lat, output logic clr);
      bit acc, got;
      int st;
      ok = 0; rr = '0; data = '0; err = 0; starts = 0; lat = -1; clr = 0;
      acc = 0; got = 0; st = -1;
      @(negedge clk);
      sif.req_a[id*W +: W] = a;
      sif.req_b[id*W +: W] = b;
      sif.req_valid[id]    = 1'b1;
      for (int c = 0; c < 50; c++) begin
         #1;
         if (sif.req_ready[id]) begin acc = 1; rr = sif.req_ready; break; end
         @(negedge clk);
      end
      @(negedge clk);
      sif.req_valid[id] = 1'b0;
      if (!acc) return;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (gcd_start) begin starts++; if (st < 0) st = c; end
         if (sif.resp_valid[id]) begin
            got = 1; data = sif.resp_data; err = sif.resp_err; lat = c - st;
            break;
         end
         @(negedge clk);
      end
      if (!got) return;
      sif.resp_ready[id] = 1'b1;
      @(negedge clk);
      #1 clr = gcd_reset;
      sif.resp_ready[id] = 1'b0;
      @(negedge clk);
      ok = 1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      sif.req_valid = '1;
      @(negedge clk); #1;
      total++; if (sif.req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", sif.req_ready); end
      total++; if (sif.resp_valid !== 4'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0000", sif.resp_valid); end
      total++; if ({sif.resp_data, sif.resp_err} !== 9'h0) begin bad++; $display("FAIL reset_resp got=%h/%b exp=00/0", sif.resp_data, sif.resp_err); end
      total++; if ({gcd_start, gcd_a, gcd_b, busy} !== 18'h0) begin bad++; $display("FAIL reset_gcd_side got=%b/%h/%h/%b exp=0", gcd_start, gcd_a, gcd_b, busy); end
      total++; if (gcd_reset !== 1'b1) begin bad++; $display("FAIL reset_gcd_reset got=%b exp=1", gcd_reset); end
      sif.req_valid = '0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_all_requesting;
      int order[$];
      int last, exp_id;
      logic [N-1:0] r;
      bit multi;
      multi = 0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sif.resp_ready = '1;
      sif.req_valid  = '1;
      for (int c = 0; c < 200 && order.size() < 5; c++) begin
         #1 r = sif.req_ready;
         if ($countones(r) > 1) multi = 1;
         for (int i = 0; i < N; i++) if (r[i]) order.push_back(i);
         @(negedge clk);
      end
      sif.req_valid = '0;
      total++; if (multi) begin bad++; $display("FAIL rr_onehot got=multiple exp=single"); end
      total++; if (order.size() != 5) begin bad++; $display("FAIL rr_count got=%0d exp=5", order.size()); end
      last = N - 1;
      for (int k = 0; k < order.size(); k++) begin
         exp_id = rr_pick(4'hF, last);
         total++; if (order[k] != exp_id) begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, order[k], exp_id); end
         last = exp_id;
      end
      for (int c = 0; c < 100 && busy; c++) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_drain busy got=%b exp=0", busy); end
      sif.resp_ready = '0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      bit ok; logic [N-1:0] rr; logic [W-1:0] d; logic e, clr; int s, lat;
      delay_cfg = 0;
      do_job(0, 8'd48, 8'd18, ok, rr, d, e, s, lat, clr);
      total++; if (!ok) begin bad++; $display("FAIL basic_complete got=0 exp=1"); end
      total++; if (rr !== 4'b0001) begin bad++; $display("FAIL basic_req_ready got=%b exp=0001", rr); end
      total++; if ({d, e} !== {8'd6, 1'b0}) begin bad++; $display("FAIL basic_result got=%0d/%b exp=6/0", d, e); end
      total++; if (s != 1) begin bad++; $display("FAIL basic_start_pulses got=%0d exp=1", s); end
      total++; if (lat != 2) begin bad++; $display("FAIL basic_latency got=%0d exp=2", lat); end
      total++; if (clr !== 1'b1) begin bad++; $display("FAIL basic_clear got=%b exp=1", clr); end
   endtask

   task automatic test_random;
      bit ok; logic [N-1:0] rr; logic [W-1:0] d, a, b, ex; logic e, clr; int s, lat, id;
      for (int k = 0; k < 8; k++) begin
         id = int'($urandom_range(0, N-1));
         a = W'($urandom); b = W'($urandom);
         delay_cfg = int'($urandom_range(0, 8));
         ex = gcd_ref(a, b);
         do_job(id, a, b, ok, rr, d, e, s, lat, clr);
         total++;
         if (!ok || d !== ex || e !== 1'b0 || s != 1 || lat != delay_cfg + 2 || clr !== 1'b1) begin
            bad++;
            $display("FAIL random[%0d] id=%0d a=%0d b=%0d got=%0d err=%b starts=%0d lat=%0d clr=%b exp=%0d err=0 starts=1 lat=%0d clr=1",
                     k, id, a, b, d, e, s, lat, clr, ex, delay_cfg + 2);
         end
      end
   endtask

   task automatic test_boundary;
      bit ok; logic [N-1:0] rr; logic [W-1:0] d; logic e, clr; int s, lat;
      logic [W-1:0] ta[3], tb[3], te[3];
      ta = '{8'd0, 8'd13, 8'd255};
      tb = '{8'd7, 8'd0,  8'd1};
      te = '{8'd7, 8'd13, 8'd1};
      delay_cfg = 1;
      for (int k = 0; k < 3; k++) begin
         do_job(k, ta[k], tb[k], ok, rr, d, e, s, lat, clr);
         total++;
         if (!ok || d !== te[k] || e !== 1'b0) begin
            bad++;
            $display("FAIL boundary[%0d] got=%0d err=%b ok=%0d exp=%0d err=0", k, d, e, ok, te[k]);
         end
      end
   endtask

   task automatic test_stall;
      bit acc, got, stable;
      acc = 0; got = 0; stable = 1;
      delay_cfg = 2;
      @(negedge clk);
      sif.req_a[3*W +: W] = 8'd100;
      sif.req_b[3*W +: W] = 8'd75;
      sif.req_valid[3] = 1'b1;
      for (int c = 0; c < 50; c++) begin
         #1 if (sif.req_ready[3]) begin acc = 1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      sif.req_valid[3] = 1'b0;
      for (int c = 0; c < 60; c++) begin
         #1 if (sif.resp_valid[3]) begin got = 1; break; end
         @(negedge clk);
      end
      total++; if (!(acc && got)) begin bad++; $display("FAIL stall_reach_resp got=%0d/%0d exp=1/1", acc, got); end
      sif.req_valid[1] = 1'b1;
      sif.resp_ready   = 4'b0111;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         if (sif.resp_valid !== 4'b1000 || sif.resp_data !== 8'd25 || sif.resp_err !== 1'b0 ||
             sif.req_ready !== 4'b0 || gcd_a !== 8'd100 || gcd_b !== 8'd75)
            stable = 0;
      end
      total++; if (!stable) begin bad++; $display("FAIL stall_hold got=%b/%0d/%b exp=1000/25/0000", sif.resp_valid, sif.resp_data, sif.req_ready); end
      sif.req_valid[1] = 1'b0;
      sif.resp_ready   = 4'b1000;
      @(negedge clk); #1;
      total++; if ({gcd_reset, sif.resp_valid} !== 5'b1_0000) begin bad++; $display("FAIL stall_clear got=%b/%b exp=1/0000", gcd_reset, sif.resp_valid); end
      sif.resp_ready = '0;
      @(negedge clk); #1;
      total++; if ({gcd_reset, busy} !== 2'b00) begin bad++; $display("FAIL stall_idle got=%b/%b exp=0/0", gcd_reset, busy); end
   endtask

   task automatic test_timeout;
      bit ok; logic [N-1:0] rr; logic [W-1:0] d; logic e, clr; int s, lat;
      never_rdy = 1'b1;
      do_job(2, 8'd9, 8'd6, ok, rr, d, e, s, lat, clr);
      total++; if (!ok || {d, e} !== {8'd0, 1'b1}) begin bad++; $display("FAIL timeout_result got=%0d/%b ok=%0d exp=0/1", d, e, ok); end
      total++; if (lat != TO + 1) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, TO + 1); end
      total++; if (clr !== 1'b1) begin bad++; $display("FAIL timeout_clear got=%b exp=1", clr); end
      never_rdy = 1'b0;
      delay_cfg = 1;
      do_job(2, 8'd9, 8'd6, ok, rr, d, e, s, lat, clr);
      total++; if (!ok || {d, e} !== {8'd3, 1'b0}) begin bad++; $display("FAIL timeout_recover got=%0d/%b ok=%0d exp=3/0", d, e, ok); end
   endtask

   task automatic test_reset_mid_run;
      bit started;
      started = 0;
      never_rdy = 1'b1;
      @(negedge clk);
      sif.req_a[1*W +: W] = 8'd20;
      sif.req_b[1*W +: W] = 8'd8;
      sif.req_a[0 +: W]   = 8'd35;
      sif.req_b[0 +: W]   = 8'd21;
      sif.req_valid[1] = 1'b1;
      for (int c = 0; c < 50; c++) begin
         #1 if (gcd_start) begin started = 1; break; end
         @(negedge clk);
      end
      sif.req_valid[1] = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      total++; if (!started) begin bad++; $display("FAIL midrun_started got=0 exp=1"); end
      total++; if ({sif.resp_valid, busy, gcd_start, gcd_a} !== 14'h0) begin bad++; $display("FAIL midrun_outputs got=%b/%b/%b/%h exp=0", sif.resp_valid, busy, gcd_start, gcd_a); end
      total++; if (gcd_reset !== 1'b1) begin bad++; $display("FAIL midrun_gcd_reset got=%b exp=1", gcd_reset); end
      sif.req_valid = 4'b0101;
      never_rdy = 1'b0;
      delay_cfg = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (sif.req_ready !== 4'b0001) begin bad++; $display("FAIL midrun_rr_restart got=%b exp=0001", sif.req_ready); end
      @(negedge clk);
      sif.req_valid = '0;
      #1;
      total++; if ({gcd_a, gcd_b} !== {8'd35, 8'd21}) begin bad++; $display("FAIL midrun_operands got=%0d/%0d exp=35/21", gcd_a, gcd_b); end
      sif.resp_ready = '1;
      for (int c = 0; c < 100 && busy; c++) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrun_drain busy got=%b exp=0", busy); end
      sif.resp_ready = '0;
   endtask

   initial begin
      sif.req_valid  = '0;
      sif.req_a      = '0;
      sif.req_b      = '0;
      sif.resp_ready = '0;
      test_reset();
      test_all_requesting();
      test_basic();
      test_random();
      test_boundary();
      test_stall();
      test_timeout();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
